// File: rtl/ov7670_cam_if.sv
// OV7670 pixel-capture front end.
// Pairs consecutive camera bytes into RGB565 pixels and tags each pixel
// with its column/row so a frame-buffer writer can address memory directly.
// Everything runs on the camera pixel clock.
module ov7670_cam_if #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int IBIT_WIDTH = 8,
  parameter int OBIT_WIDTH = 16,
  localparam int HCNT_W    = $clog2(WIDTH) + 1,
  localparam int VCNT_W    = $clog2(HEIGHT) + 1
) (
  input  logic                  cam_PCLK,
  input  logic                  n_rst,
  input  logic                  cam_HREF,
  input  logic                  cam_VSYNC,
  input  logic [IBIT_WIDTH-1:0] cam_din,
  output logic [OBIT_WIDTH-1:0] rgb565,
  output logic [HCNT_W-1:0]     h_cnt,
  output logic [VCNT_W-1:0]     v_cnt,
  output logic                  pix_valid
);

  // Byte phase: which half of the RGB565 pixel the next byte carries.
  typedef enum logic {
    PH_HIGH = 1'b0,
    PH_LOW  = 1'b1
  } phase_t;

  phase_t phase_q, phase_d;

  logic [IBIT_WIDTH-1:0] hi_q, hi_d;
  logic [HCNT_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [VCNT_W-1:0]     line_cnt_q, line_cnt_d;
  logic                  href_q, href_d;
  logic [OBIT_WIDTH-1:0] rgb_q, rgb_d;
  logic [HCNT_W-1:0]     h_q, h_d;
  logic [VCNT_W-1:0]     v_q, v_d;
  logic                  valid_q, valid_d;

  // Byte accepted this cycle: inside an active line of an active frame and
  // still within the visible window.
  logic active;
  logic latch_hi;
  logic emit_pix;

  assign active = cam_HREF && !cam_VSYNC
                  && (line_cnt_q < VCNT_W'(HEIGHT))
                  && (pix_cnt_q < HCNT_W'(WIDTH));

  // Phase state register.
  always_ff @(posedge cam_PCLK or negedge n_rst) begin
    if (!n_rst) begin
      phase_q <= PH_HIGH;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase next state: restart on blanking, toggle on every accepted byte.
  always_comb begin
    phase_d = phase_q;
    if (cam_VSYNC || !cam_HREF) begin
      phase_d = PH_HIGH;
    end else if (active) begin
      phase_d = (phase_q == PH_HIGH) ? PH_LOW : PH_HIGH;
    end
  end

  // Phase outputs: first byte is stored, second byte completes a pixel.
  always_comb begin
    latch_hi = active && (phase_q == PH_HIGH);
    emit_pix = active && (phase_q == PH_LOW);
  end

  // Datapath next state: byte assembly, pixel/line counters, output hold.
  always_comb begin
    hi_d       = hi_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    href_d     = cam_HREF;
    rgb_d      = rgb_q;
    h_d        = h_q;
    v_d        = v_q;
    valid_d    = 1'b0;

    if (cam_VSYNC) begin
      // Vertical blanking: rewind to the top of the frame; outputs keep the
      // last pixel of the previous frame.
      line_cnt_d = '0;
      pix_cnt_d  = '0;
    end else if (!cam_HREF) begin
      pix_cnt_d = '0;
      // End of a line that actually produced pixels advances the row.
      if (href_q && (pix_cnt_q != '0) && (line_cnt_q < VCNT_W'(HEIGHT))) begin
        line_cnt_d = line_cnt_q + VCNT_W'(1);
      end
    end else begin
      if (latch_hi) begin
        hi_d = cam_din;
      end
      if (emit_pix) begin
        rgb_d     = {hi_q, cam_din};
        h_d       = pix_cnt_q;
        v_d       = line_cnt_q;
        valid_d   = 1'b1;
        pix_cnt_d = pix_cnt_q + HCNT_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge cam_PCLK or negedge n_rst) begin
    if (!n_rst) begin
      hi_q       <= '0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      href_q     <= 1'b0;
      rgb_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      valid_q    <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      href_q     <= href_d;
      rgb_q      <= rgb_d;
      h_q        <= h_d;
      v_q        <= v_d;
      valid_q    <= valid_d;
    end
  end

  assign rgb565    = rgb_q;
  assign h_cnt     = h_q;
  assign v_cnt     = v_q;
  assign pix_valid = valid_q;

endmodule

// File: tb/tb_ov7670_cam_if.sv
// Self-checking bench for ov7670_cam_if: a byte-index model predicts every
// cycle's outputs; strobe logs are pinned against hand-computed values.
module tb_ov7670_cam_if;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        href = 1'b0;
  logic        vsync = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [15:0] rgb565;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        pix_valid;

  ov7670_cam_if #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .IBIT_WIDTH(8), .OBIT_WIDTH(16)
  ) dut (
    .cam_PCLK(clk), .n_rst(n_rst), .cam_HREF(href), .cam_VSYNC(vsync),
    .cam_din(din), .rgb565(rgb565), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: bytes seen in the current line, current row, previous byte.
  int          m_bidx;
  int          m_row;
  logic        m_prev_href;
  logic [7:0]  m_prev_byte;
  logic        e_valid;
  logic [15:0] e_rgb;
  logic [10:0] e_h;
  logic [9:0]  e_v;

  // Strobe log since the last mark.
  int          s_cnt;
  logic [15:0] s_first_rgb, s_second_rgb, s_last_rgb;
  int          s_first_h, s_second_h, s_last_h, s_first_v, s_last_v;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_bidx = 0; m_row = 0; m_prev_href = 1'b0; m_prev_byte = 8'h00;
    e_valid = 1'b0; e_rgb = '0; e_h = '0; e_v = '0;
  endfunction

  // Pixel k of a line is bytes 2k and 2k+1; it exists if k < WIDTH and the
  // row is inside the frame. A line with any pixel moves to the next row.
  function automatic void model_step(input logic r, input logic hr,
                                     input logic vs, input logic [7:0] d);
    if (!r) begin
      model_reset();
      return;
    end
    e_valid = 1'b0;
    if (vs) begin
      m_row = 0;
      m_bidx = 0;
    end else if (hr) begin
      if (m_row < HEIGHT && (m_bidx % 2) == 1 && (m_bidx / 2) < WIDTH) begin
        e_valid = 1'b1;
        e_rgb = {m_prev_byte, d};
        e_h = 11'(m_bidx / 2);
        e_v = 10'(m_row);
      end
      m_prev_byte = d;
      m_bidx++;
    end else begin
      if (m_prev_href && m_bidx >= 2 && m_row < HEIGHT) m_row++;
      m_bidx = 0;
    end
    m_prev_href = hr;
  endfunction

  task automatic mark();
    s_cnt = 0;
  endtask

  // One clock: check the outputs produced by the previous cycle's inputs,
  // then drive this cycle's inputs and advance the model.
  task automatic cyc(input logic r, input logic hr, input logic vs, input logic [7:0] d);
    @(negedge clk);
    checks++;
    if ({pix_valid, rgb565, h_cnt, v_cnt} !== {e_valid, e_rgb, e_h, e_v}) begin
      failures++;
      $display("FAIL cycle_out t=%0t actual valid=%b rgb=%h h=%0d v=%0d required valid=%b rgb=%h h=%0d v=%0d",
               $time, pix_valid, rgb565, h_cnt, v_cnt, e_valid, e_rgb, e_h, e_v);
    end
    if (pix_valid === 1'b1) begin
      if (s_cnt == 0) begin
        s_first_rgb = rgb565; s_first_h = int'(h_cnt); s_first_v = int'(v_cnt);
      end
      if (s_cnt == 1) begin
        s_second_rgb = rgb565; s_second_h = int'(h_cnt);
      end
      s_last_rgb = rgb565; s_last_h = int'(h_cnt); s_last_v = int'(v_cnt);
      s_cnt++;
    end
    n_rst = r; href = hr; vsync = vs; din = d;
    model_step(r, hr, vs, d);
  endtask

  task automatic line(input int n, input int start, input int gap, input logic vs);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, vs, 8'(start + i));
    for (int i = 0; i < gap; i++) cyc(1'b1, 1'b0, vs, 8'h00);
  endtask

  initial begin
    model_reset();
    mark();
    #1 n_rst = 1'b0;
    #1;
    chk("reset_rgb", int'(rgb565), 0);
    chk("reset_h", int'(h_cnt), 0);
    chk("reset_v", int'(v_cnt), 0);
    chk("reset_valid", int'(pix_valid), 0);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);

    // Full first line, incrementing bytes.
    mark();
    line(1280, 0, 1, 1'b0);
    chk("l0_count", s_cnt, 640);
    chk("l0_first_rgb", int'(s_first_rgb), 'h0001);
    chk("l0_first_h", s_first_h, 0);
    chk("l0_first_v", s_first_v, 0);
    chk("l0_second_rgb", int'(s_second_rgb), 'h0203);
    chk("l0_second_h", s_second_h, 1);
    chk("l0_last_rgb", int'(s_last_rgb), 'hFEFF);
    chk("l0_last_h", s_last_h, 639);

    // Horizontal blanking: no strobes.
    mark();
    repeat (50) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("hblank_count", s_cnt, 0);

    // Remaining 479 lines, one pixel each.
    mark();
    for (int l = 0; l < 479; l++) line(2, 16, 2, 1'b0);
    chk("rows_count", s_cnt, 479);
    chk("row1_first_h", s_first_h, 0);
    chk("row1_first_v", s_first_v, 1);
    chk("rows_last_v", s_last_v, 479);

    // 481st line: ignored.
    mark();
    line(4, 'h20, 2, 1'b0);
    chk("extra_line_count", s_cnt, 0);
    chk("extra_line_v_hold", int'(v_cnt), 479);

    // Vertical blanking with HREF toggling.
    mark();
    for (int l = 0; l < 5; l++) line(4, 'h30, 2, 1'b1);
    chk("vsync_count", s_cnt, 0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);

    // New frame, overlong line.
    mark();
    line(1290, 0, 2, 1'b0);
    chk("long_count", s_cnt, 640);
    chk("nf_first_h", s_first_h, 0);
    chk("nf_first_v", s_first_v, 0);
    chk("long_last_rgb", int'(s_last_rgb), 'hFEFF);
    chk("long_last_h", s_last_h, 639);

    // Odd-length line then a normal line.
    mark();
    line(3, 'hA0, 2, 1'b0);
    chk("odd_count", s_cnt, 1);
    chk("odd_rgb", int'(s_first_rgb), 'hA0A1);
    mark();
    line(4, 'hB0, 2, 1'b0);
    chk("after_odd_count", s_cnt, 2);
    chk("after_odd_rgb", int'(s_first_rgb), 'hB0B1);
    chk("after_odd_h", s_first_h, 0);
    chk("after_odd_v", s_first_v, 2);

    // Asynchronous reset mid-line with an odd byte pending.
    line(3, 'hC0, 0, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_rgb", int'(rgb565), 0);
    chk("midrst_h", int'(h_cnt), 0);
    chk("midrst_v", int'(v_cnt), 0);
    chk("midrst_valid", int'(pix_valid), 0);
    model_reset();
    cyc(1'b0, 1'b1, 1'b0, 8'hC3);
    mark();
    line(4, 'hD0, 2, 1'b0);
    chk("postrst_count", s_cnt, 2);
    chk("postrst_rgb", int'(s_first_rgb), 'hD0D1);
    chk("postrst_h", s_first_h, 0);
    chk("postrst_v", s_first_v, 0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
